// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8 data bits, parity, one stop bit, mid-bit sampling
module uart_rx #(
   parameter int DIV     = 5208,
   parameter bit PAR_ODD = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       rx_i,
   output logic [7:0] d_o,
   output logic       rdy_o,
   output logic       perr_o,
   output logic       ferr_o,
   output logic       busy_o
);

   localparam int TW = $clog2(DIV);
   // Sample offsets within a bit: half a bit after the start edge, then one full bit
   localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);
   localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HI
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [2:0]    cnt, cnt_n;
   logic [7:0]    sr, sr_n;
   logic          par_bit, par_n;
   logic          done;
   logic          sync1, rxs;
   logic          tick_full;

   // Two-flop synchronizer for the asynchronous serial line; idles high
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rx_i;
         rxs   <= sync1;
      end
   end

   // FSM state, bit timer, bit counter, shift register and captured parity bit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         timer   <= '0;
         cnt     <= '0;
         sr      <= '0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         cnt     <= cnt_n;
         sr      <= sr_n;
         par_bit <= par_n;
      end
   end

   assign tick_full = (timer == T_FULL);

   // Next-state logic: every sample point reloads the timer so it never runs past DIV-1
   always_comb begin
      state_n = state;
      timer_n = timer;
      cnt_n   = cnt;
      sr_n    = sr;
      par_n   = par_bit;
      done    = 1'b0;
      case (state)
         IDLE: begin
            timer_n = '0;
            cnt_n   = '0;
            if (!rxs) state_n = START;
         end
         START: begin
            if (timer == T_HALF) begin
               timer_n = '0;
               // A start bit that is gone at mid-bit is a glitch
               state_n = rxs ? IDLE : DATA;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         DATA: begin
            if (tick_full) begin
               timer_n = '0;
               sr_n    = {rxs, sr[7:1]};
               cnt_n   = cnt + 3'd1;
               if (cnt == 3'd7) state_n = PARITY;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         PARITY: begin
            if (tick_full) begin
               timer_n = '0;
               par_n   = rxs;
               state_n = STOP;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         STOP: begin
            if (tick_full) begin
               timer_n = '0;
               done    = 1'b1;
               // A low stop bit may be a break; wait for the line to recover
               state_n = rxs ? IDLE : WAIT_HI;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         WAIT_HI: begin
            timer_n = '0;
            if (rxs) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Result registers: loaded on the cycle after the stop sample, held until the next frame
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_o    <= 8'h00;
         rdy_o  <= 1'b0;
         perr_o <= 1'b0;
         ferr_o <= 1'b0;
      end else begin
         rdy_o <= done;
         if (done) begin
            d_o    <= sr;
            perr_o <= par_bit != ((^sr) ^ PAR_ODD);
            ferr_o <= ~rxs;
         end
      end
   end

   assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame scoreboard
module tb_uart_rx;

   localparam int DIV       = 16;
   localparam int LAT       = 2 + DIV / 2 + 10 * DIV + 1;
   localparam int FRAME_LEN = 11 * DIV;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx;
   logic [7:0] d;
   logic       rdy, perr, ferr, busy;

   uart_rx #(.DIV(DIV), .PAR_ODD(1'b0)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .rx_i   (rx),
      .d_o    (d),
      .rdy_o  (rdy),
      .perr_o (perr),
      .ferr_o (ferr),
      .busy_o (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       perr;
      logic       ferr;
      logic       busy;
   } exp_t;

   typedef struct {
      logic [7:0] d;
      logic       par_flip;
      logic       stop;
      logic [7:0] exp_d;
      logic       exp_perr;
      logic       exp_ferr;
   } vec_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   t0 = 0;
   int   last_rdy = 0;
   int   prev_rdy = 0;
   int   rdy_cnt = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard consumer: every rdy pulse must match the oldest outstanding frame
   always @(negedge clk) begin
      if (rdy === 1'b1) begin
         rdy_cnt++;
         prev_rdy = last_rdy;
         last_rdy = cyc;
         if (sb.size() == 0) begin
            chk("unexpected_rdy", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("data", {24'h0, d}, {24'h0, e.d});
            chk("perr", {31'h0, perr}, {31'h0, e.perr});
            chk("ferr", {31'h0, ferr}, {31'h0, e.ferr});
            chk("busy_at_rdy", {31'h0, busy}, {31'h0, e.busy});
         end
      end
   end

   task automatic drive_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] v, input logic par_flip, input logic stop,
                             input int stop_extra);
      t0 = cyc;
      drive_bit(1'b0, DIV);
      for (int i = 0; i < 8; i++) drive_bit(v[i], DIV);
      drive_bit((^v) ^ par_flip, DIV);
      drive_bit(stop, DIV + stop_extra);
      rx = 1'b1;
   endtask

   task automatic expect_frame(input logic [7:0] v, input logic pe, input logic fe);
      exp_t e;
      e.d    = v;
      e.perr = pe;
      e.ferr = fe;
      e.busy = fe;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 4 * DIV) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(name, sb.size(), 0);
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{8'hFE, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b1};
      vecs[4] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0};
      vecs[5] = '{8'h77, 1'b0, 1'b0, 8'h77, 1'b0, 1'b1};

      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_d", {24'h0, d}, 32'h00);
      chk("reset_rdy", {31'h0, rdy}, 32'd0);
      chk("reset_perr", {31'h0, perr}, 32'd0);
      chk("reset_ferr", {31'h0, ferr}, 32'd0);
      chk("reset_busy", {31'h0, busy}, 32'd0);
      rst_n = 1'b1;
      drive_bit(1'b1, 4);

      // First frame also checks the exact latency from the line edge to rdy
      expect_frame(8'hA5, 1'b0, 1'b0);
      send_frame(8'hA5, 1'b0, 1'b1, 0);
      drain("pending_a5");
      chk("latency_a5", last_rdy - t0, LAT);
      drive_bit(1'b1, 2 * DIV);

      for (int i = 0; i < 6; i++) begin
         expect_frame(vecs[i].exp_d, vecs[i].exp_perr, vecs[i].exp_ferr);
         send_frame(vecs[i].d, vecs[i].par_flip, vecs[i].stop, 0);
         drain("pending_vec");
         drive_bit(1'b1, 2 * DIV);
      end

      // Framing error with the line held low, then recovery
      expect_frame(8'h81, 1'b0, 1'b1);
      send_frame(8'h81, 1'b0, 1'b0, 40);
      #0;
      chk("busy_while_low", {31'h0, busy}, 32'd1);
      chk("pending_81", sb.size(), 0);
      drive_bit(1'b1, 5);
      chk("busy_after_high", {31'h0, busy}, 32'd0);
      expect_frame(8'h42, 1'b0, 1'b0);
      send_frame(8'h42, 1'b0, 1'b1, 0);
      drain("pending_42");
      drive_bit(1'b1, 2 * DIV);

      // Short glitch: no frame, outputs untouched, back to idle quickly
      begin
         int cnt0;
         logic [7:0] d0;
         cnt0 = rdy_cnt;
         d0   = d;
         t0   = cyc;
         drive_bit(1'b0, 4);
         rx = 1'b1;
         while (cyc < t0 + 11) @(posedge clk);
         @(negedge clk);
         chk("glitch_busy", {31'h0, busy}, 32'd0);
         drive_bit(1'b1, 3 * DIV);
         chk("glitch_no_rdy", rdy_cnt - cnt0, 0);
         chk("glitch_d_hold", {24'h0, d}, {24'h0, d0});
      end

      // Back-to-back frames with no idle gap
      expect_frame(8'h00, 1'b0, 1'b0);
      expect_frame(8'hFF, 1'b0, 1'b0);
      send_frame(8'h00, 1'b0, 1'b1, 0);
      send_frame(8'hFF, 1'b0, 1'b1, 0);
      drain("pending_b2b");
      chk("b2b_spacing", last_rdy - prev_rdy, FRAME_LEN);
      drive_bit(1'b1, 2 * DIV);

      // Leave nonzero results, then reset in the middle of data bit 3
      expect_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b1, 0);
      drain("pending_3c");
      drive_bit(1'b1, 2 * DIV);
      drive_bit(1'b0, DIV);
      drive_bit(1'b1, DIV);
      drive_bit(1'b0, DIV);
      drive_bit(1'b1, DIV);
      drive_bit(1'b0, DIV / 2);
      rst_n = 1'b0;
      #1;
      chk("midreset_d", {24'h0, d}, 32'h00);
      chk("midreset_perr", {31'h0, perr}, 32'd0);
      chk("midreset_ferr", {31'h0, ferr}, 32'd0);
      chk("midreset_busy", {31'h0, busy}, 32'd0);
      chk("midreset_rdy", {31'h0, rdy}, 32'd0);
      rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_bit(1'b1, 4);
      expect_frame(8'h5A, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, 0);
      drain("pending_5a");
      drive_bit(1'b1, 2 * DIV);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
